// File: rtl/eth_rx_frame_buffer_if.sv
// ============================================================================
// Module  : eth_rx_frame_buffer_if
// Brief   : MAC byte stream in, consumer pop port and status counters out.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface eth_rx_frame_buffer_if;
    logic [7:0]  i_mac_data;
    logic        i_mac_valid;
    logic        i_mac_last;
    logic        i_mac_err;
    logic        i_rreq;
    logic [7:0]  o_rdata;
    logic        o_rready;
    logic        o_rlast;
    logic [7:0]  o_frames;
    logic [15:0] o_drop_cnt;

    modport master (
        output i_mac_data, i_mac_valid, i_mac_last, i_mac_err, i_rreq,
        input  o_rdata, o_rready, o_rlast, o_frames, o_drop_cnt
    );

    modport slave (
        input  i_mac_data, i_mac_valid, i_mac_last, i_mac_err, i_rreq,
        output o_rdata, o_rready, o_rlast, o_frames, o_drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/eth_rx_frame_buffer.sv
// ============================================================================
// Module  : eth_rx_frame_buffer
// Brief   : Speculative Ethernet RX byte store; commits good frames, rolls back bad ones.
// Revision: 1.0
// ============================================================================
`default_nettype none

module eth_rx_frame_buffer #(
    parameter int DEPTH   = 2048,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    eth_rx_frame_buffer_if.slave   bus
);
    localparam int          c_AW      = $clog2(DEPTH);
    localparam int          c_PW      = c_AW + 1;
    localparam logic [c_PW-1:0] c_DEPTH   = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_FR_SAT  = c_PW'(255);
    localparam logic [10:0] c_MIN_LEN = 11'(MIN_LEN);
    localparam logic [10:0] c_MAX_LEN = 11'(MAX_LEN);
    localparam logic [10:0] c_LEN_SAT = 11'h7FF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    logic [8:0]      r_mem [DEPTH];
    state_t          r_state;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_commit_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_frame_cnt;
    logic [10:0]     r_len;
    logic [15:0]     r_drop_cnt;
    logic [7:0]      r_rdata;
    logic            r_rready;
    logic            r_rlast;

    logic [10:0] w_len_next;
    logic        w_full;
    logic        w_avail;
    logic        w_pop;
    logic        w_in_byte;
    logic        w_overflow;
    logic        w_write;
    logic        w_good;
    logic        w_drop;
    logic        w_pop_last;

    always_comb begin
        w_len_next = (r_state == S_IDLE) ? 11'd1
                   : ((r_len == c_LEN_SAT) ? r_len : r_len + 11'd1);
        w_full     = (r_wr_ptr - r_rd_ptr) == c_DEPTH;
        w_avail    = r_commit_ptr != r_rd_ptr;
        w_pop      = bus.i_rreq && w_avail;
        w_in_byte  = bus.i_mac_valid && (r_state != S_DISCARD);
        w_overflow = w_in_byte && (w_full || (w_len_next > c_MAX_LEN));
        w_write    = w_in_byte && !w_overflow;
        w_good     = w_write && bus.i_mac_last && !bus.i_mac_err
                   && (w_len_next >= c_MIN_LEN);
        // Every path that ends a frame without committing it counts exactly one drop.
        w_drop     = (w_in_byte && bus.i_mac_last && !w_good)
                   || ((r_state == S_DISCARD) && bus.i_mac_valid && bus.i_mac_last);
        w_pop_last = r_rready && r_rlast;
    end

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.i_mac_last, bus.i_mac_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_frame_cnt  <= '0;
            r_len        <= '0;
            r_drop_cnt   <= '0;
            r_rdata      <= '0;
            r_rready     <= 1'b0;
            r_rlast      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RECV: begin
                    if (bus.i_mac_valid) begin
                        if (w_overflow) begin
                            r_wr_ptr <= r_commit_ptr;
                            r_state  <= bus.i_mac_last ? S_IDLE : S_DISCARD;
                        end else begin
                            r_len <= w_len_next;
                            if (!bus.i_mac_last) begin
                                r_wr_ptr <= r_wr_ptr + 1'b1;
                                r_state  <= S_RECV;
                            end else begin
                                r_state <= S_IDLE;
                                if (w_good) begin
                                    r_wr_ptr     <= r_wr_ptr + 1'b1;
                                    r_commit_ptr <= r_wr_ptr + 1'b1;
                                end else begin
                                    r_wr_ptr <= r_commit_ptr;
                                end
                            end
                        end
                    end
                end
                S_DISCARD: begin
                    if (bus.i_mac_valid && bus.i_mac_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end

            // Frame count drops when the last byte of a frame leaves the output register.
            case ({w_good, w_pop_last})
                2'b10:   r_frame_cnt <= r_frame_cnt + 1'b1;
                2'b01:   r_frame_cnt <= r_frame_cnt - 1'b1;
                default: r_frame_cnt <= r_frame_cnt;
            endcase

            r_rready <= w_pop;
            if (w_pop) begin
                r_rdata  <= r_mem[r_rd_ptr[c_AW-1:0]][7:0];
                r_rlast  <= r_mem[r_rd_ptr[c_AW-1:0]][8];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign bus.o_rdata    = r_rdata;
    assign bus.o_rready   = r_rready;
    assign bus.o_rlast    = r_rlast;
    assign bus.o_drop_cnt = r_drop_cnt;
    assign bus.o_frames   = (r_frame_cnt > c_FR_SAT) ? 8'hFF : r_frame_cnt[7:0];

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_frame_buffer.sv
// ============================================================================
// Module  : tb_eth_rx_frame_buffer
// Brief   : Directed scenario bench for eth_rx_frame_buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_eth_rx_frame_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    eth_rx_frame_buffer_if bus ();

    eth_rx_frame_buffer #(
        .DEPTH   (2048),
        .MIN_LEN (60),
        .MAX_LEN (1514)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.i_mac_data  = 8'h00;
        bus.i_mac_valid = 1'b0;
        bus.i_mac_last  = 1'b0;
        bus.i_mac_err   = 1'b0;
        bus.i_rreq      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // A non-zero gap inserts an invalid cycle with last/err high and drives err on non-last bytes.
    task automatic send_frame(input int len, input int start, input bit err, input bit gap);
        for (int i = 0; i < len; i++) begin
            if (gap && i == 10) begin
                bus.i_mac_data  = 8'hEE;
                bus.i_mac_valid = 1'b0;
                bus.i_mac_last  = 1'b1;
                bus.i_mac_err   = 1'b1;
                @(posedge clk);
                #1;
            end
            bus.i_mac_data  = 8'(start + i);
            bus.i_mac_valid = 1'b1;
            bus.i_mac_last  = (i == len - 1);
            bus.i_mac_err   = (i == len - 1) ? err : gap;
            @(posedge clk);
            #1;
        end
        bus.i_mac_valid = 1'b0;
        bus.i_mac_last  = 1'b0;
        bus.i_mac_err   = 1'b0;
    endtask

    // Pops len bytes and reports the first deviating position (-1 when none).
    task automatic read_frame(input int len, input int start, output int bad,
                              output logic [9:0] got, output logic [9:0] exp);
        logic [7:0] ed;
        bad = -1;
        got = '0;
        exp = '0;
        for (int k = 0; k < len; k++) begin
            bus.i_rreq = 1'b1;
            @(posedge clk);
            #1;
            ed = 8'(start + k);
            if (bad < 0 && {bus.o_rready, bus.o_rlast, bus.o_rdata} !== {1'b1, (k == len - 1), ed}) begin
                bad = k;
                got = {bus.o_rready, bus.o_rlast, bus.o_rdata};
                exp = {1'b1, (k == len - 1), ed};
            end
        end
        bus.i_rreq = 1'b0;
        @(posedge clk);
        #1;
        if (bad < 0 && bus.o_rready !== 1'b0) begin
            bad = len;
            got = {bus.o_rready, bus.o_rlast, bus.o_rdata};
            exp = {2'b00, bus.o_rdata};
        end
    endtask

    task automatic probe_empty(output int pulses);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            bus.i_rreq = (k < 3);
            @(posedge clk);
            #1;
            if (bus.o_rready === 1'b1) pulses++;
        end
        bus.i_rreq = 1'b0;
    endtask

    task automatic test_reset();
        int p;
        do_reset();
        n_tests++;
        if ({bus.o_rready, bus.o_rlast, bus.o_rdata, bus.o_frames, bus.o_drop_cnt} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b last=%b data=%h frames=%0d drop=%0d, expected all 0",
                     bus.o_rready, bus.o_rlast, bus.o_rdata, bus.o_frames, bus.o_drop_cnt);
        end
        probe_empty(p);
        n_tests++;
        if (p !== 0) begin
            n_fail++;
            $display("FAIL reset_no_pop: got %0d pulses, expected 0", p);
        end
    endtask

    task automatic test_good_frame();
        int bad; logic [9:0] g, e;
        do_reset();
        send_frame(64, 0, 1'b0, 1'b1);
        n_tests++;
        if (bus.o_frames !== 8'd1) begin
            n_fail++;
            $display("FAIL t1_frames_commit: got %0d, expected 1", bus.o_frames);
        end
        read_frame(64, 0, bad, g, e);
        n_tests++;
        if (bad !== -1) begin
            n_fail++;
            $display("FAIL t1_readback: byte %0d got {rdy,last,data}=%h, expected %h", bad, g, e);
        end
        n_tests++;
        if (bus.o_frames !== 8'd0) begin
            n_fail++;
            $display("FAIL t1_frames_after: got %0d, expected 0", bus.o_frames);
        end
    endtask

    task automatic test_err_frame();
        int p;
        do_reset();
        send_frame(64, 8'h20, 1'b1, 1'b0);
        n_tests++;
        if (bus.o_drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL t2_drop: got %0d, expected 1", bus.o_drop_cnt);
        end
        n_tests++;
        if (bus.o_frames !== 8'd0) begin
            n_fail++;
            $display("FAIL t2_frames: got %0d, expected 0", bus.o_frames);
        end
        probe_empty(p);
        n_tests++;
        if (p !== 0) begin
            n_fail++;
            $display("FAIL t2_no_pop: got %0d pulses, expected 0", p);
        end
    endtask

    task automatic test_length_limits();
        int bad; logic [9:0] g, e;
        do_reset();
        send_frame(59, 0, 1'b0, 1'b0);
        n_tests++;
        if (bus.o_drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL t3_runt_drop: got %0d, expected 1", bus.o_drop_cnt);
        end
        send_frame(1515, 0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.o_drop_cnt, bus.o_frames} !== {16'd2, 8'd0}) begin
            n_fail++;
            $display("FAIL t3_giant_drop: got drop=%0d frames=%0d, expected drop=2 frames=0",
                     bus.o_drop_cnt, bus.o_frames);
        end
        send_frame(60, 8'hA0, 1'b0, 1'b0);
        read_frame(60, 8'hA0, bad, g, e);
        n_tests++;
        if (bad !== -1) begin
            n_fail++;
            $display("FAIL t3_min_readback: byte %0d got %h, expected %h", bad, g, e);
        end
    endtask

    task automatic test_full();
        int bad, p; logic [9:0] g, e;
        do_reset();
        send_frame(1514, 0, 1'b0, 1'b0);
        send_frame(500, 8'h10, 1'b0, 1'b0);
        send_frame(100, 8'h55, 1'b0, 1'b0);
        n_tests++;
        if ({bus.o_drop_cnt, bus.o_frames} !== {16'd1, 8'd2}) begin
            n_fail++;
            $display("FAIL t4_full_drop: got drop=%0d frames=%0d, expected drop=1 frames=2",
                     bus.o_drop_cnt, bus.o_frames);
        end
        read_frame(1514, 0, bad, g, e);
        n_tests++;
        if (bad !== -1) begin
            n_fail++;
            $display("FAIL t4_read_first: byte %0d got %h, expected %h", bad, g, e);
        end
        read_frame(500, 8'h10, bad, g, e);
        n_tests++;
        if (bad !== -1) begin
            n_fail++;
            $display("FAIL t4_read_second: byte %0d got %h, expected %h", bad, g, e);
        end
        probe_empty(p);
        n_tests++;
        if (p !== 0 || bus.o_frames !== 8'd0) begin
            n_fail++;
            $display("FAIL t4_empty_after: got %0d pulses frames=%0d, expected 0 pulses frames=0",
                     p, bus.o_frames);
        end
    endtask

    task automatic test_back_to_back();
        int bad; logic [9:0] g, e;
        do_reset();
        send_frame(1514, 8'h33, 1'b0, 1'b0);
        fork
            read_frame(1514, 8'h33, bad, g, e);
            begin
                repeat (5) @(posedge clk);
                #1;
                send_frame(60, 8'hC0, 1'b0, 1'b0);
                n_tests++;
                if (bus.o_frames !== 8'd2) begin
                    n_fail++;
                    $display("FAIL t5_frames_two: got %0d, expected 2", bus.o_frames);
                end
            end
        join
        n_tests++;
        if (bad !== -1) begin
            n_fail++;
            $display("FAIL t5_read_long: byte %0d got %h, expected %h", bad, g, e);
        end
        n_tests++;
        if (bus.o_frames !== 8'd1) begin
            n_fail++;
            $display("FAIL t5_frames_one: got %0d, expected 1", bus.o_frames);
        end
        read_frame(60, 8'hC0, bad, g, e);
        n_tests++;
        if (bad !== -1 || bus.o_frames !== 8'd0) begin
            n_fail++;
            $display("FAIL t5_read_short: byte %0d got %h frames=%0d, expected %h frames=0",
                     bad, g, bus.o_frames, e);
        end
    endtask

    task automatic test_reset_mid();
        int bad, p; logic [9:0] g, e;
        do_reset();
        send_frame(10, 0, 1'b0, 1'b0);
        send_frame(64, 8'h40, 1'b0, 1'b0);
        bus.i_rreq = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.i_mac_data  = 8'(8'h70 + i);
            bus.i_mac_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus.o_rready, bus.o_rlast, bus.o_rdata, bus.o_frames, bus.o_drop_cnt} !== 34'd0) begin
            n_fail++;
            $display("FAIL t6_reset_outputs: got rdy=%b last=%b data=%h frames=%0d drop=%0d, expected all 0",
                     bus.o_rready, bus.o_rlast, bus.o_rdata, bus.o_frames, bus.o_drop_cnt);
        end
        idle_inputs();
        rst = 1'b0;
        send_frame(60, 8'h90, 1'b0, 1'b0);
        n_tests++;
        if (bus.o_frames !== 8'd1) begin
            n_fail++;
            $display("FAIL t6_frames_fresh: got %0d, expected 1", bus.o_frames);
        end
        read_frame(60, 8'h90, bad, g, e);
        n_tests++;
        if (bad !== -1) begin
            n_fail++;
            $display("FAIL t6_readback: byte %0d got %h, expected %h", bad, g, e);
        end
        probe_empty(p);
        n_tests++;
        if (p !== 0) begin
            n_fail++;
            $display("FAIL t6_stale_data: got %0d pulses, expected 0", p);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_good_frame();
        test_err_frame();
        test_length_limits();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
